// File: rtl/grf_wa_pipe.sv
// Destination-register tag pipeline: carries write address/valid from decode
// down to commit and flags source hazards per stage. Option: GRF_WA_ZERO_SQUASH_EN.
module grf_wa_pipe #(
   parameter int ADDR_W   = 5,
   parameter int DEPTH    = 3,
   parameter int LINK_REG = 31
) (
   input  logic                      clk,
   input  logic                      reset,
   input  logic [1:0]                sel,
   input  logic [ADDR_W-1:0]         rt,
   input  logic [ADDR_W-1:0]         rd,
   input  logic                      in_valid,
   input  logic                      stall,
   input  logic                      flush,
   input  logic [ADDR_W-1:0]         rs_q,
   input  logic [ADDR_W-1:0]         rt_q,
   output logic [DEPTH*ADDR_W-1:0]   wa_stage,
   output logic [DEPTH-1:0]          wv_stage,
   output logic [ADDR_W-1:0]         commit_wa,
   output logic                      commit_we,
   output logic [DEPTH-1:0]          hit_rs,
   output logic [DEPTH-1:0]          hit_rt,
   output logic [DEPTH-1:0]          fwd_rs,
   output logic [DEPTH-1:0]          fwd_rt
);

   localparam logic [ADDR_W-1:0] LINK_WA = ADDR_W'(LINK_REG);

   logic [ADDR_W-1:0] sel_wa;
   logic              sel_wv;
   logic [ADDR_W-1:0] wa_d [DEPTH];
   logic [ADDR_W-1:0] wa_q [DEPTH];
   logic [DEPTH-1:0]  wv_d;
   logic [DEPTH-1:0]  wv_q;

   always_comb begin
      case (sel)
         2'b00:   sel_wa = rd;
         2'b01:   sel_wa = rt;
         2'b10:   sel_wa = LINK_WA;
         default: sel_wa = '0;
      endcase
      sel_wv = in_valid & (sel != 2'b11) & ~stall & ~flush;
`ifdef GRF_WA_ZERO_SQUASH_EN
      // $0 is never architecturally written, so drop it before it enters the pipe
      sel_wv = sel_wv & (sel_wa != '0);
`endif
   end

   always_comb begin
      wv_d    = '0;
      wa_d[0] = (stall | flush) ? '0 : sel_wa;
      wv_d[0] = sel_wv;
      for (int i = 1; i < DEPTH; i++) begin
         wa_d[i] = wa_q[i-1];
         wv_d[i] = wv_q[i-1];
      end
   end

   always_ff @(posedge clk) begin
      if (!reset) begin
         for (int i = 0; i < DEPTH; i++) wa_q[i] <= '0;
         wv_q <= '0;
      end else begin
         for (int i = 0; i < DEPTH; i++) wa_q[i] <= wa_d[i];
         wv_q <= wv_d;
      end
   end

   always_comb begin
      wa_stage = '0;
      hit_rs   = '0;
      hit_rt   = '0;
      for (int i = 0; i < DEPTH; i++) begin
         wa_stage[i*ADDR_W +: ADDR_W] = wa_q[i];
         hit_rs[i] = wv_q[i] & (wa_q[i] == rs_q) & (rs_q != '0);
         hit_rt[i] = wv_q[i] & (wa_q[i] == rt_q) & (rt_q != '0);
      end
   end

   // Lowest index is the youngest producer; isolate it with x & -x.
   assign fwd_rs    = hit_rs & (~hit_rs + DEPTH'(1));
   assign fwd_rt    = hit_rt & (~hit_rt + DEPTH'(1));
   assign wv_stage  = wv_q;
   assign commit_wa = wa_q[DEPTH-1];
   assign commit_we = wv_q[DEPTH-1];

endmodule

// File: tb/tb_grf_wa_pipe.sv
// Directed-vector bench for grf_wa_pipe at default parameters (ADDR_W=5, DEPTH=3).
module tb_grf_wa_pipe;

   logic        clk;
   logic        reset;
   logic [1:0]  sel;
   logic [4:0]  rt, rd, rs_q, rt_q;
   logic        in_valid, stall, flush;
   logic [14:0] wa_stage;
   logic [2:0]  wv_stage, hit_rs, hit_rt, fwd_rs, fwd_rt;
   logic [4:0]  commit_wa;
   logic        commit_we;

   int n_vec = 0;
   int n_err = 0;

   grf_wa_pipe dut (
      .clk(clk), .reset(reset), .sel(sel), .rt(rt), .rd(rd),
      .in_valid(in_valid), .stall(stall), .flush(flush),
      .rs_q(rs_q), .rt_q(rt_q), .wa_stage(wa_stage), .wv_stage(wv_stage),
      .commit_wa(commit_wa), .commit_we(commit_we),
      .hit_rs(hit_rs), .hit_rt(hit_rt), .fwd_rs(fwd_rs), .fwd_rt(fwd_rt)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_vec++;
      if (obs !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic push(input logic [1:0] s, input logic [4:0] a_rd, input logic [4:0] a_rt);
      sel = s; rd = a_rd; rt = a_rt; in_valid = 1'b1;
      step();
   endtask

   logic exp_zero_we;

   initial begin
      reset = 1'b0; sel = 2'b00; rt = '0; rd = 5'd3; in_valid = 1'b1;
      stall = 1'b0; flush = 1'b0; rs_q = '0; rt_q = '0;
`ifdef GRF_WA_ZERO_SQUASH_EN
      exp_zero_we = 1'b0;
`else
      exp_zero_we = 1'b1;
`endif

      // reset overrides in_valid
      step(); step();
      rs_q = 5'd3;
      #1;
      chk("rst_wv", wv_stage, 0);
      chk("rst_wa", wa_stage, 0);
      chk("rst_we", commit_we, 0);
      chk("rst_hit", hit_rs, 0);
      chk("rst_fwd", fwd_rs, 0);

      // link write, latency 3
      reset = 1'b1;
      push(2'b10, 5'd1, 5'd2);
      chk("link_s0_wa", wa_stage[4:0], 31);
      chk("link_s0_wv", wv_stage, 3'b001);
      in_valid = 1'b0;
      step();
      chk("link_we_c2", commit_we, 0);
      step();
      chk("link_we_c3", commit_we, 1);
      chk("link_wa_c3", commit_wa, 31);
      step();
      chk("link_we_c4", commit_we, 0);

      // back-to-back rd=5, rt=6, rd=7
      push(2'b00, 5'd5, 5'd0);
      push(2'b01, 5'd0, 5'd6);
      push(2'b00, 5'd7, 5'd0);
      in_valid = 1'b0;
      rs_q = 5'd6; rt_q = 5'd5;
      #1;
      chk("b2b_wa0", commit_wa, 5);
      chk("b2b_we0", commit_we, 1);
      chk("b2b_hit_rs", hit_rs, 3'b010);
      chk("b2b_fwd_rs", fwd_rs, 3'b010);
      chk("b2b_hit_rt", hit_rt, 3'b100);
      chk("b2b_fwd_rt", fwd_rt, 3'b100);
      step();
      chk("b2b_wa1", commit_wa, 6);
      chk("b2b_we1", commit_we, 1);
      step();
      chk("b2b_wa2", commit_wa, 7);
      chk("b2b_we2", commit_we, 1);

      // duplicate address 9 in stages 0 and 2
      push(2'b00, 5'd9, 5'd0);
      push(2'b01, 5'd0, 5'd4);
      push(2'b00, 5'd9, 5'd0);
      in_valid = 1'b0;
      rs_q = 5'd9; rt_q = 5'd4;
      #1;
      chk("dup_hit_rs", hit_rs, 3'b101);
      chk("dup_fwd_rs", fwd_rs, 3'b001);
      chk("dup_hit_rt", hit_rt, 3'b010);
      chk("dup_fwd_rt", fwd_rt, 3'b010);
      chk("dup_wa", wa_stage, {5'd9, 5'd4, 5'd9});

      // two bubbles: stall, then stall+flush together
      rs_q = 5'd0; rt_q = 5'd0;
      push(2'b00, 5'd1, 5'd0);
      push(2'b00, 5'd2, 5'd0);
      sel = 2'b00; rd = 5'd3; in_valid = 1'b1; stall = 1'b1;
      step();
      chk("stl1_wv", wv_stage, 3'b110);
      chk("stl1_s0wa", wa_stage[4:0], 0);
      chk("stl1_cwa", commit_wa, 1);
      flush = 1'b1;
      step();
      chk("stl2_wv", wv_stage, 3'b100);
      chk("stl2_cwa", commit_wa, 2);
      stall = 1'b0; flush = 1'b0;
      push(2'b00, 5'd4, 5'd0);
      chk("stl3_wv", wv_stage, 3'b001);
      chk("stl3_we", commit_we, 0);
      in_valid = 1'b0;
      step();
      chk("stl4_we", commit_we, 0);
      step();
      chk("stl5_we", commit_we, 1);
      chk("stl5_cwa", commit_wa, 4);
      step();
      chk("stl6_we", commit_we, 0);

      // sel=11 never writes
      push(2'b11, 5'd8, 5'd8);
      chk("nowr_wv", wv_stage[0], 0);

      // reset drops entries in flight
      push(2'b00, 5'd10, 5'd0);
      push(2'b00, 5'd11, 5'd0);
      push(2'b00, 5'd12, 5'd0);
      chk("fly_wv", wv_stage, 3'b111);
      reset = 1'b0; stall = 1'b1;
      step();
      chk("midrst_wv", wv_stage, 0);
      chk("midrst_we", commit_we, 0);
      reset = 1'b1; stall = 1'b0; in_valid = 1'b0;
      step();
      chk("midrst_we1", commit_we, 0);
      step();
      chk("midrst_we2", commit_we, 0);

      // write to $0
      push(2'b00, 5'd0, 5'd0);
      in_valid = 1'b0;
      step(); step();
      rs_q = 5'd0;
      #1;
      chk("zero_we", commit_we, 32'(exp_zero_we));
      chk("zero_hit_rs", hit_rs, 0);
      chk("zero_fwd_rs", fwd_rs, 0);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
